// File: rtl/argmax_top2_stream.sv
// argmax_top2_stream
// Streaming top-2 decision unit for the last classifier stage. One signed
// class score arrives per cycle; the block tracks the best and runner-up
// scores with their indices and, one cycle after the frame's last beat,
// publishes a registered result.
//
// Ports:
//   clk          - single rising-edge clock
//   reset        - asynchronous, active-high reset
//   i_valid      - score beat valid (no backpressure)
//   i_value      - signed class score
//   i_index      - class index carried through to the outputs
//   i_last       - final beat of a frame (qualified by i_valid)
//   i_thresh     - unsigned confidence threshold, sampled on the last beat
//   o_valid      - one-cycle result pulse
//   o_best_idx   - index of the maximum score
//   o_best_val   - maximum score (signed)
//   o_second_idx - index of the runner-up score
//   o_margin     - best minus second, unsigned, DATA_BW+1 bits
//   o_confident  - o_margin >= i_thresh
//   o_len_err    - frame beat count differed from NUM_CLASS
module argmax_top2_stream #(
  parameter int DATA_BW   = 20,
  parameter int NUM_CLASS = 26,
  parameter int IDX_BW    = $clog2(NUM_CLASS),
  parameter int TIE_LAST  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [DATA_BW-1:0] i_value,
  input  logic [IDX_BW-1:0]  i_index,
  input  logic               i_last,
  input  logic [DATA_BW-1:0] i_thresh,
  output logic               o_valid,
  output logic [IDX_BW-1:0]  o_best_idx,
  output logic [DATA_BW-1:0] o_best_val,
  output logic [IDX_BW-1:0]  o_second_idx,
  output logic [DATA_BW:0]   o_margin,
  output logic               o_confident,
  output logic               o_len_err
);

  // Counter must hold NUM_CLASS+1 so an over-long frame saturates there
  // instead of wrapping back onto a "correct" length.
  localparam int CNT_BW = $clog2(NUM_CLASS + 2);
  localparam logic [CNT_BW-1:0] CNT_SAT  = CNT_BW'(NUM_CLASS + 1);
  localparam logic [CNT_BW-1:0] CNT_FULL = CNT_BW'(NUM_CLASS);
  localparam logic signed [DATA_BW-1:0] MIN_VAL = {1'b1, {(DATA_BW-1){1'b0}}};
  localparam bit TIE = (TIE_LAST != 0);

  typedef enum logic [0:0] {IDLE, ACC} state_t;

  state_t                     state;
  logic signed [DATA_BW-1:0]  best_val;
  logic signed [DATA_BW-1:0]  sec_val;
  logic [IDX_BW-1:0]          best_idx;
  logic [IDX_BW-1:0]          sec_idx;
  logic [CNT_BW-1:0]          cnt;

  logic signed [DATA_BW-1:0]  v;
  logic signed [DATA_BW-1:0]  nxt_best_val;
  logic signed [DATA_BW-1:0]  nxt_sec_val;
  logic [IDX_BW-1:0]          nxt_best_idx;
  logic [IDX_BW-1:0]          nxt_sec_idx;
  logic [CNT_BW-1:0]          nxt_cnt;
  logic [DATA_BW:0]           nxt_margin;

  // Next best/second for the incoming beat. A beat seen in IDLE starts a
  // new frame, so the previous frame's running values are never compared.
  always_comb begin
    v            = $signed(i_value);
    nxt_best_val = best_val;
    nxt_best_idx = best_idx;
    nxt_sec_val  = sec_val;
    nxt_sec_idx  = sec_idx;
    nxt_cnt      = cnt;
    if (state == IDLE) begin
      nxt_best_val = v;
      nxt_best_idx = i_index;
      nxt_sec_val  = MIN_VAL;
      nxt_sec_idx  = '0;
      nxt_cnt      = CNT_BW'(1);
    end else begin
      if (v > best_val || (TIE && v == best_val)) begin
        nxt_sec_val  = best_val;
        nxt_sec_idx  = best_idx;
        nxt_best_val = v;
        nxt_best_idx = i_index;
      end else if (v > sec_val || (TIE && v == sec_val)) begin
        nxt_sec_val = v;
        nxt_sec_idx = i_index;
      end
      if (cnt != CNT_SAT) begin
        nxt_cnt = cnt + CNT_BW'(1);
      end
    end
    // Sign-extend both operands so the difference never overflows.
    nxt_margin = {nxt_best_val[DATA_BW-1], nxt_best_val}
               - {nxt_sec_val[DATA_BW-1], nxt_sec_val};
  end

  // Frame FSM, running state and registered result. The result registers
  // load only on the last beat and otherwise hold; o_valid is a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      best_val     <= MIN_VAL;
      sec_val      <= MIN_VAL;
      best_idx     <= '0;
      sec_idx      <= '0;
      cnt          <= '0;
      o_valid      <= 1'b0;
      o_best_idx   <= '0;
      o_best_val   <= '0;
      o_second_idx <= '0;
      o_margin     <= '0;
      o_confident  <= 1'b0;
      o_len_err    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid) begin
        best_val <= nxt_best_val;
        best_idx <= nxt_best_idx;
        sec_val  <= nxt_sec_val;
        sec_idx  <= nxt_sec_idx;
        cnt      <= nxt_cnt;
        state    <= i_last ? IDLE : ACC;
        if (i_last) begin
          o_valid      <= 1'b1;
          o_best_idx   <= nxt_best_idx;
          o_best_val   <= nxt_best_val;
          o_second_idx <= nxt_sec_idx;
          o_margin     <= nxt_margin;
          o_confident  <= (nxt_margin >= {1'b0, i_thresh});
          o_len_err    <= (nxt_cnt != CNT_FULL);
        end
      end
    end
  end

endmodule

// File: tb/tb_argmax_top2_stream.sv
// tb_argmax_top2_stream
// Directed bench for argmax_top2_stream. Two instances share the input
// stream: one keeps the later index on ties, the other the earlier one.
module tb_argmax_top2_stream;

  localparam int DATA_BW = 20;
  localparam int NUM_CLASS = 26;
  localparam int IDX_BW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iValid = 1'b0;
  logic [DATA_BW-1:0] iValue = '0;
  logic [IDX_BW-1:0] iIndex = '0;
  logic iLast = 1'b0;
  logic [DATA_BW-1:0] iThresh = '0;

  logic oValid, oConfident, oLenErr;
  logic [IDX_BW-1:0] oBestIdx, oSecondIdx;
  logic [DATA_BW-1:0] oBestVal;
  logic [DATA_BW:0] oMargin;

  logic fValid, fConfident, fLenErr;
  logic [IDX_BW-1:0] fBestIdx, fSecondIdx;
  logic [DATA_BW-1:0] fBestVal;
  logic [DATA_BW:0] fMargin;

  int errors = 0;
  int checks = 0;
  int pulses;

  argmax_top2_stream #(.DATA_BW(DATA_BW), .NUM_CLASS(NUM_CLASS), .IDX_BW(IDX_BW), .TIE_LAST(1)) dut (
    .clk(clk), .reset(reset), .i_valid(iValid), .i_value(iValue), .i_index(iIndex),
    .i_last(iLast), .i_thresh(iThresh), .o_valid(oValid), .o_best_idx(oBestIdx),
    .o_best_val(oBestVal), .o_second_idx(oSecondIdx), .o_margin(oMargin),
    .o_confident(oConfident), .o_len_err(oLenErr));

  argmax_top2_stream #(.DATA_BW(DATA_BW), .NUM_CLASS(NUM_CLASS), .IDX_BW(IDX_BW), .TIE_LAST(0)) dutFirst (
    .clk(clk), .reset(reset), .i_valid(iValid), .i_value(iValue), .i_index(iIndex),
    .i_last(iLast), .i_thresh(iThresh), .o_valid(fValid), .o_best_idx(fBestIdx),
    .o_best_val(fBestVal), .o_second_idx(fSecondIdx), .o_margin(fMargin),
    .o_confident(fConfident), .o_len_err(fLenErr));

  always #5 clk = ~clk;

  // Drives one beat at a falling edge and returns at the next falling edge,
  // so the beat is consumed on the rising edge in between.
  task automatic applyStimulus(input int val, input int idx, input bit last, input int thresh);
    iValid  = 1'b1;
    iValue  = DATA_BW'(val);
    iIndex  = IDX_BW'(idx);
    iLast   = last;
    iThresh = DATA_BW'(thresh);
    @(negedge clk);
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic applyIdle(input int n);
    iValid = 1'b0;
    iLast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input int bIdx, input int bVal, input int sIdx,
                             input longint margin, input int conf, input int lenErr);
    checkOutput({tag, "_valid"}, longint'(oValid), 1);
    checkOutput({tag, "_best_idx"}, longint'(oBestIdx), bIdx);
    checkOutput({tag, "_best_val"}, longint'($signed(oBestVal)), bVal);
    checkOutput({tag, "_second_idx"}, longint'(oSecondIdx), sIdx);
    checkOutput({tag, "_margin"}, longint'(oMargin), margin);
    checkOutput({tag, "_confident"}, longint'(oConfident), conf);
    checkOutput({tag, "_len_err"}, longint'(oLenErr), lenErr);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", longint'(oValid), 0);
    checkOutput("rst_best_idx", longint'(oBestIdx), 0);
    checkOutput("rst_best_val", longint'(oBestVal), 0);
    checkOutput("rst_second_idx", longint'(oSecondIdx), 0);
    checkOutput("rst_margin", longint'(oMargin), 0);
    checkOutput("rst_confident", longint'(oConfident), 0);
    checkOutput("rst_len_err", longint'(oLenErr), 0);
    reset = 1'b0;
    applyIdle(1);

    $display("[TB] ascending frame");
    for (int k = 0; k < 26; k++) applyStimulus(k, k, k == 25, 0);
    checkResult("asc", 25, 25, 24, 1, 1, 0);
    checkOutput("asc_first_best_idx", longint'(fBestIdx), 25);
    applyIdle(1);
    checkOutput("asc_pulse_drop", longint'(oValid), 0);
    checkOutput("asc_hold_idx", longint'(oBestIdx), 25);

    $display("[TB] all negative frame");
    for (int k = 0; k < 26; k++) applyStimulus(-100 - k, k, k == 25, 0);
    checkResult("neg", 0, -100, 1, 1, 1, 0);
    applyIdle(2);

    $display("[TB] tie frame");
    for (int k = 0; k < 26; k++) applyStimulus((k == 3 || k == 7) ? 50 : -1, k, k == 25, 1);
    checkResult("tie", 7, 50, 3, 0, 0, 0);
    checkOutput("tie_first_best_idx", longint'(fBestIdx), 3);
    checkOutput("tie_first_second_idx", longint'(fSecondIdx), 7);
    checkOutput("tie_first_margin", longint'(fMargin), 0);
    applyIdle(1);

    $display("[TB] back-to-back frames");
    for (int k = 0; k < 26; k++) applyStimulus((k == 4) ? 1000 : k, k, k == 25, 0);
    checkResult("b2b_a", 4, 1000, 25, 975, 1, 0);
    pulses = 0;
    for (int k = 0; k < 26; k++) begin
      applyStimulus((k == 11) ? 500 : -k, k, k == 25, 600);
      if (k < 25 && oValid) pulses++;
    end
    checkOutput("b2b_no_early_pulse", pulses, 0);
    checkResult("b2b_b", 11, 500, 0, 500, 0, 0);
    applyIdle(1);

    $display("[TB] short frame with gaps");
    for (int k = 0; k < 20; k++) begin
      if (k % 3 == 1) applyIdle(k % 4 + 1);
      applyStimulus((k == 13) ? 200 : k * 3, k, k == 19, 143);
    end
    checkResult("short", 13, 200, 19, 143, 1, 1);
    applyIdle(1);
    for (int k = 0; k < 26; k++) applyStimulus(k, k, k == 25, 2);
    checkResult("after_short", 25, 25, 24, 1, 0, 0);
    applyIdle(1);

    $display("[TB] long frame saturation");
    for (int k = 0; k < 58; k++) applyStimulus(k, k % 32, k == 57, 0);
    checkResult("long", 25, 57, 24, 1, 1, 1);
    applyIdle(1);

    $display("[TB] one-beat frames");
    applyStimulus(7, 3, 1'b1, 0);
    checkResult("one", 3, 7, 0, 524295, 1, 1);
    applyIdle(1);
    applyStimulus(7, 3, 1'b1, 20'hFFFFF);
    checkResult("one_hi_thresh", 3, 7, 0, 524295, 0, 1);
    applyIdle(1);

    $display("[TB] reset mid-frame");
    for (int k = 0; k < 10; k++) applyStimulus((k == 2) ? 5000 : 0, k, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_valid", longint'(oValid), 0);
    checkOutput("abort_best_idx", longint'(oBestIdx), 0);
    checkOutput("abort_best_val", longint'(oBestVal), 0);
    reset = 1'b0;
    applyIdle(1);
    pulses = 0;
    for (int k = 0; k < 26; k++) begin
      applyStimulus(2 * k - 30, k, k == 25, 3);
      if (k < 25 && oValid) pulses++;
    end
    checkOutput("abort_no_pulse", pulses, 0);
    checkResult("abort_new", 25, 20, 24, 2, 0, 0);
    applyIdle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
